// File: rtl/result_packer.sv
// result_packer
//   Packs 16-bit engine results two-per-word (low half first) into 32-bit
//   result FIFO words. At end of layer the stream can be padded with zero
//   words up to a whole host transfer block so that the host-side block
//   threshold is always reached.
//
//   Optional feature macro: RESULT_BLOCK_ALIGN_EN
//     defined   : PAD state writes zero words until blk_cnt wraps to 0.
//     undefined : PAD only drains the pending word, then finishes.
module result_packer #(
  parameter int DATA_W     = 16,
  parameter int BLOCK_SIZE = 128,
  parameter int CNT_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      total_cnt,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [2*DATA_W-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int BLK_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_remain;
  logic                r_half;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] r_out_word;
  logic                r_out_pend;
  logic [BLK_W-1:0]    r_blk_cnt;
  logic                r_overrun;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_last;
  logic                w_load;
  logic                w_data_wr;
  logic                w_pad_wr;
  logic                w_wr_en;
  logic [BLK_W-1:0]    w_blk_next;
  logic                w_drained;
  logic                w_pad_done;

  // A new sample can enter while no word is pending, or while the pending
  // word is leaving this cycle; that keeps one result per cycle flowing.
  assign w_in_ready = (r_state == S_PACK) & (~r_out_pend | ~fifo_full);
  assign w_accept   = in_valid & w_in_ready;
  assign w_last     = (r_remain == CNT_W'(1));
  assign w_load     = w_accept & (r_half | w_last);
  assign w_data_wr  = r_out_pend & ~fifo_full;

`ifdef RESULT_BLOCK_ALIGN_EN
  // Zero words only once the last data word has left, and only until the
  // block counter wraps back to the start of a block.
  assign w_pad_wr   = (r_state == S_PAD) & ~r_out_pend &
                      (r_blk_cnt != '0) & ~fifo_full;
`else
  assign w_pad_wr   = 1'b0;
`endif

  assign w_wr_en    = w_data_wr | w_pad_wr;
  assign w_blk_next = r_blk_cnt + BLK_W'(w_wr_en);

  // PAD exits on the cycle of its final write so done lands one cycle later.
  assign w_drained  = ~r_out_pend | w_data_wr;
`ifdef RESULT_BLOCK_ALIGN_EN
  assign w_pad_done = w_drained & (w_blk_next == '0);
`else
  assign w_pad_done = w_drained;
`endif

  // Layer control FSM plus packing datapath; all state in one clocked block.
  // NOTE: every register here uses <= so all right-hand sides see the
  // pre-edge values, matching the combinational decodes above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_remain   <= '0;
      r_half     <= 1'b0;
      r_lo       <= '0;
      r_out_word <= '0;
      r_out_pend <= 1'b0;
      r_blk_cnt  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      // Output word holding register: a reload wins over the write clearing
      // it. Clearing the word after a write makes wr_data read zero during pad.
      if (w_load) begin
        r_out_pend <= 1'b1;
        r_out_word <= r_half ? {in_data, r_lo} : {DATA_W'(0), in_data};
      end else if (w_data_wr) begin
        r_out_pend <= 1'b0;
        r_out_word <= '0;
      end

      if (w_wr_en) begin
        r_blk_cnt <= w_blk_next;
      end

      if (in_valid && (r_state != S_PACK)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remain  <= total_cnt;
            r_half    <= 1'b0;
            r_blk_cnt <= '0;
            r_overrun <= in_valid;
            r_state   <= (total_cnt == '0) ? S_DONE : S_PACK;
          end
        end

        S_PACK: begin
          if (w_accept) begin
            r_remain <= r_remain - CNT_W'(1);
            if (r_half) begin
              r_half <= 1'b0;
            end else if (!w_last) begin
              r_lo   <= in_data;
              r_half <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_PAD;
            end
          end
        end

        S_PAD: begin
          if (w_pad_done) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = w_wr_en;
  assign wr_data  = r_out_word;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: table of layers driven through a
// scoreboard, plus hand-written reset-state, overrun and mid-layer reset
// sequences. Expected pad lengths follow RESULT_BLOCK_ALIGN_EN.
module tb_result_packer;

  localparam int DATA_W     = 16;
  localparam int BLOCK_SIZE = 128;
  localparam int CNT_W      = 24;
`ifdef RESULT_BLOCK_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                start;
  logic [CNT_W-1:0]    total_cnt;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic                fifo_full;
  logic                wr_en;
  logic [2*DATA_W-1:0] wr_data;
  logic                busy;
  logic                done;
  logic                overrun;

  result_packer #(
    .DATA_W(DATA_W), .BLOCK_SIZE(BLOCK_SIZE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .total_cnt(total_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [15:0] base;
    logic [15:0] step;
    int          stall_at;
    int          stall_len;
    int          exp_words;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] sb_q [$];
  int          wr_count    = 0;
  int          done_count  = 0;
  int          last_wr_cyc = 0;
  int          done_cyc    = 0;
  int          start_cyc   = 0;
  logic        m_half;
  logic [15:0] m_lo;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Output monitor: every write pops one expected word from the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      check("write_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) check("wr_data", wr_data, sb_q.pop_front());
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Reference packing model, updated whenever the DUT accepts a sample.
  task automatic model_accept(input logic [15:0] d, input bit last, input int npad);
    if (m_half) begin
      sb_q.push_back({d, m_lo});
      m_half = 1'b0;
    end else if (last) begin
      sb_q.push_back({16'h0000, d});
    end else begin
      m_lo   = d;
      m_half = 1'b1;
    end
    if (last) for (int k = 0; k < npad; k++) sb_q.push_back(32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"},    wr_en,    0);
    check({tag, "_wr_data"},  wr_data,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_overrun"},  overrun,  0);
  endtask

  task automatic run_layer(input vec_t v, input string tag);
    int          i;
    int          stall_cnt;
    int          guard;
    int          lat;
    int          data_words;
    logic [31:0] held;
    logic [15:0] d;
    data_words = (v.cnt + 1) / 2;
    wr_count   = 0;
    done_count = 0;
    m_half     = 1'b0;
    held       = '0;

    @(posedge clk); #1;
    start     = 1'b1;
    total_cnt = CNT_W'(v.cnt);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_overrun_clear"}, overrun, 0);

    i = 0; stall_cnt = 0; guard = 0;
    while (i < v.cnt && guard < v.cnt * 4 + 200) begin
      d         = v.base + 16'(v.step * i);
      in_valid  = 1'b1;
      in_data   = d;
      fifo_full = (v.stall_len > 0) && (i >= v.stall_at) && (stall_cnt < v.stall_len);
      @(negedge clk);
      if (fifo_full) begin
        check({tag, "_no_wr_when_full"}, wr_en, 0);
        if (stall_cnt == 1) held = wr_data;
        else if (stall_cnt > 1) check({tag, "_wr_data_stable"}, wr_data, held);
        if (stall_cnt == v.stall_len - 1) check({tag, "_in_ready_low"}, in_ready, 0);
        stall_cnt++;
      end
      if (in_ready === 1'b1) begin
        model_accept(d, (i == v.cnt - 1), v.exp_words - data_words);
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_all_samples_taken"}, (i == v.cnt), 1);
    in_valid  = 1'b0;
    fifo_full = 1'b0;

    guard = 0;
    while (done_count == 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_done_seen"}, (done_count != 0), 1);
    @(posedge clk); #1;
    check({tag, "_done_once"},   done_count, 1);
    check({tag, "_idle_after"},  busy, 0);
    check({tag, "_word_count"},  wr_count, v.exp_words);
    check({tag, "_sb_empty"},    sb_q.size(), 0);
    if (v.exp_words > 0) begin
      check({tag, "_done_after_last_wr"}, done_cyc, last_wr_cyc + 1);
    end else begin
      lat = done_cyc - start_cyc;
      check({tag, "_zero_done_latency_ok"}, (lat >= 1 && lat <= 2), 1);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{4,   16'h1111, 16'h1111, 0, 0,  ALIGN ? 128 : 2};
    vecs[1] = '{3,   16'hAAAA, 16'h1111, 0, 0,  ALIGN ? 128 : 2};
    vecs[2] = '{256, 16'h0000, 16'h0001, 0, 0,  128};
    vecs[3] = '{20,  16'h0100, 16'h0101, 7, 10, ALIGN ? 128 : 10};
    vecs[4] = '{0,   16'h0000, 16'h0000, 0, 0,  0};
    vecs[5] = '{259, 16'h8000, 16'h0003, 0, 0,  ALIGN ? 256 : 130};

    rst = 1'b0; start = 1'b0; total_cnt = '0;
    in_valid = 1'b0; in_data = '0; fifo_full = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_layer(vecs[t], $sformatf("vec%0d", t));
    end

    // Data offered while idle is flagged and not written; next start clears it.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("overrun_set_idle", overrun, 1);
    check("overrun_no_write", wr_count, vecs[5].exp_words);
    v = '{2, 16'h1234, 16'h1111, 0, 0, ALIGN ? 128 : 1};
    run_layer(v, "after_overrun");

    // Reset with a half word held in PACK discards it.
    @(posedge clk); #1;
    start     = 1'b1;
    total_cnt = CNT_W'(4);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    v = '{2, 16'h5555, 16'h1111, 0, 0, ALIGN ? 128 : 1};
    sb_q.delete();
    run_layer(v, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
